pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 86 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard/stall/flush controller for a 5-stage pipeline.
// Ports: clk, rst_n (sync, active-low); mem_busy freezes the pipe;
// id_op/id_rs/id_rt describe the ID instruction; ex_mem_read/ex_rt
// describe a load in EX; ex_branch_taken resolves beq in EX.
// Outputs: pc_we/ifid_we/idex_we stage enables, ifid_flush/idex_flush
// bubbles, pc_sel next-PC source, state FSM state, stall_cnt/redir_cnt
// saturating performance counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_busy,
  input  logic [5:0]       id_op,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       pc_sel,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redir_cnt
);
  typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10, WAIT = 2'b11} state_t;
  state_t cur, nxt;
  logic reads_rs, reads_rt, load_use, jump;
  assign reads_rs = id_op inside {6'b000000, 6'b001000, 6'b000001, 6'b001001, 6'b000010,
                                  6'b000110, 6'b001010, 6'b101010, 6'b000011, 6'b000111};
  assign reads_rt = id_op inside {6'b000000, 6'b001000, 6'b000001, 6'b001001, 6'b000011};
  // STALL masks detection: the load has moved on, so the dependency is satisfied.
  assign load_use = ex_mem_read && ex_rt != 5'd0 && cur != STALL &&
                    ((reads_rs && ex_rt == id_rs) || (reads_rt && ex_rt == id_rt));
  assign jump = id_op == 6'b000100;
  assign state = cur;
  always_ff @(posedge clk)
    if (!rst_n) cur <= RUN;
    else cur <= nxt;
  always_comb begin
    pc_we = 1'b1;
    ifid_we = 1'b1;
    idex_we = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pc_sel = 2'b00;
    nxt = RUN;
    if (!rst_n) begin
      pc_we = 1'b0;
      ifid_we = 1'b0;
      idex_we = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (mem_busy) begin
      pc_we = 1'b0;
      ifid_we = 1'b0;
      idex_we = 1'b0;
      nxt = WAIT;
    end else if (ex_branch_taken) begin
      pc_sel = 2'b01;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      nxt = FLUSH;
    end else if (load_use) begin
      pc_we = 1'b0;
      ifid_we = 1'b0;
      idex_flush = 1'b1;
      nxt = STALL;
    end else if (jump) begin
      pc_sel = 2'b10;
      ifid_flush = 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      stall_cnt <= '0;
      redir_cnt <= '0;
    end else begin
      if (!pc_we && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (pc_sel != 2'b00 && redir_cnt != '1) redir_cnt <= redir_cnt + 1'b1;
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: random + directed check of pipe_hazard_ctrl against an action-based model.
module tb_pipe_hazard_ctrl;
  logic clk = 0, rst_n = 0, mem_busy = 0, ex_mem_read = 0, ex_branch_taken = 0;
  logic [5:0] id_op = 0;
  logic [4:0] id_rs = 0, id_rt = 0, ex_rt = 0;
  logic m_pc_we, m_ifid_we, m_idex_we, m_ifid_flush, m_idex_flush;
  logic [1:0] m_pc_sel, m_state;
  logic [15:0] m_stall, m_redir;
  logic s_pc_we, s_ifid_we, s_idex_we, s_ifid_flush, s_idex_flush;
  logic [1:0] s_pc_sel, s_state;
  logic [3:0] s_stall, s_redir;
  int total = 0, bad = 0;
  int la = 0, sc16 = 0, rc16 = 0, sc4 = 0, rc4 = 0;
  bit mvalid = 0;
  logic [5:0] ops [12] = '{6'o00, 6'o10, 6'o01, 6'o11, 6'o02, 6'o06, 6'o12, 6'o52, 6'o03, 6'o07, 6'o04, 6'o05};
  always #5 clk = ~clk;
  pipe_hazard_ctrl m (.clk(clk), .rst_n(rst_n), .mem_busy(mem_busy), .id_op(id_op), .id_rs(id_rs),
    .id_rt(id_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .pc_we(m_pc_we), .ifid_we(m_ifid_we), .idex_we(m_idex_we), .ifid_flush(m_ifid_flush),
    .idex_flush(m_idex_flush), .pc_sel(m_pc_sel), .state(m_state), .stall_cnt(m_stall), .redir_cnt(m_redir));
  pipe_hazard_ctrl #(.CNT_W(4)) s (.clk(clk), .rst_n(rst_n), .mem_busy(mem_busy), .id_op(id_op), .id_rs(id_rs),
    .id_rt(id_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .pc_we(s_pc_we), .ifid_we(s_ifid_we), .idex_we(s_idex_we), .ifid_flush(s_ifid_flush),
    .idex_flush(s_idex_flush), .pc_sel(s_pc_sel), .state(s_state), .stall_cnt(s_stall), .redir_cnt(s_redir));
  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Action taken this cycle: 0 none, 1 freeze, 2 branch redirect, 3 load-use stall, 4 jump.
  function automatic int action(int last);
    bit lu;
    lu = ex_mem_read && ex_rt != 0 &&
         ((id_op inside {6'o00, 6'o10, 6'o01, 6'o11, 6'o02, 6'o06, 6'o12, 6'o52, 6'o03, 6'o07} && ex_rt == id_rs) ||
          (id_op inside {6'o00, 6'o10, 6'o01, 6'o11, 6'o03} && ex_rt == id_rt));
    if (mem_busy) return 1;
    if (ex_branch_taken) return 2;
    if (lu && last != 3) return 3;
    if (id_op == 6'o04) return 4;
    return 0;
  endfunction
  always @(posedge clk) begin
    int a;
    if (!rst_n) begin
      la = 0; sc16 = 0; rc16 = 0; sc4 = 0; rc4 = 0; mvalid = 1;
    end else if (mvalid) begin
      a = action(la);
      if (a == 1 || a == 3) begin
        sc16 = sc16 < 65535 ? sc16 + 1 : sc16;
        sc4 = sc4 < 15 ? sc4 + 1 : sc4;
      end
      if (a == 2 || a == 4) begin
        rc16 = rc16 < 65535 ? rc16 + 1 : rc16;
        rc4 = rc4 < 15 ? rc4 + 1 : rc4;
      end
      la = a;
    end
  end
  always @(negedge clk) if (mvalid) begin
    int a;
    int e_we, e_idwe, e_iff, e_idf, e_sel;
    a = action(la);
    e_we = !(a == 1 || a == 3);
    e_idwe = a != 1;
    e_iff = a == 2 || a == 4;
    e_idf = a == 2 || a == 3;
    e_sel = a == 2 ? 1 : a == 4 ? 2 : 0;
    if (!rst_n) begin
      e_we = 0; e_idwe = 0; e_iff = 1; e_idf = 1; e_sel = 0;
    end
    chk("pc_we", m_pc_we, e_we);
    chk("ifid_we", m_ifid_we, e_we);
    chk("idex_we", m_idex_we, e_idwe);
    chk("ifid_flush", m_ifid_flush, e_iff);
    chk("idex_flush", m_idex_flush, e_idf);
    chk("pc_sel", m_pc_sel, e_sel);
    chk("state", m_state, la == 1 ? 3 : la == 2 ? 2 : la == 3 ? 1 : 0);
    chk("stall_cnt", m_stall, sc16);
    chk("redir_cnt", m_redir, rc16);
    chk("s_pc_we", s_pc_we, e_we);
    chk("s_stall_cnt", s_stall, sc4);
    chk("s_redir_cnt", s_redir, rc4);
  end
  task automatic drive(bit r, bit busy, bit br, bit mr, logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [4:0] ert);
    @(posedge clk);
    #1;
    rst_n = r; mem_busy = busy; ex_branch_taken = br; ex_mem_read = mr;
    id_op = op; id_rs = rs; id_rt = rt; ex_rt = ert;
    @(negedge clk);
  endtask
  task automatic idle();
    drive(1, 0, 0, 0, 6'o77, 0, 0, 0);
  endtask
  initial begin
    drive(0, 1, 1, 1, 6'o04, 5, 5, 5);
    chk("rst pc_we", m_pc_we, 0);
    chk("rst idex_we", m_idex_we, 0);
    chk("rst ifid_flush", m_ifid_flush, 1);
    chk("rst idex_flush", m_idex_flush, 1);
    chk("rst pc_sel", m_pc_sel, 0);
    idle();
    chk("rst state", m_state, 0);
    chk("rst stall_cnt", m_stall, 0);
    drive(1, 0, 0, 1, 6'o00, 0, 5, 5);
    chk("lu pc_we", m_pc_we, 0);
    chk("lu ifid_we", m_ifid_we, 0);
    chk("lu idex_flush", m_idex_flush, 1);
    drive(1, 0, 0, 1, 6'o00, 0, 5, 5);
    chk("lu state", m_state, 1);
    chk("lu stall_cnt", m_stall, 1);
    chk("lu suppressed", m_pc_we, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 1, 6'o00, 0, 5, 5);
    chk("br pc_sel", m_pc_sel, 1);
    chk("br ifid_flush", m_ifid_flush, 1);
    chk("br idex_flush", m_idex_flush, 1);
    chk("br pc_we", m_pc_we, 1);
    idle();
    chk("br state", m_state, 2);
    chk("br redir_cnt", m_redir, 1);
    chk("br stall_cnt", m_stall, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 6'o77, 0, 0, 0);
      chk("busy pc_we", m_pc_we, 0);
      chk("busy idex_we", m_idex_we, 0);
      chk("busy idex_flush", m_idex_flush, 0);
    end
    drive(1, 0, 1, 0, 6'o77, 0, 0, 0);
    chk("busy state", m_state, 3);
    chk("busy release pc_sel", m_pc_sel, 1);
    chk("busy stall_cnt", m_stall, 3);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 6'o04, 0, 0, 0);
    chk("jmp pc_sel", m_pc_sel, 2);
    chk("jmp ifid_flush", m_ifid_flush, 1);
    chk("jmp idex_flush", m_idex_flush, 0);
    drive(1, 0, 0, 1, 6'o00, 0, 0, 0);
    chk("rt0 no stall", m_pc_we, 1);
    drive(1, 0, 0, 1, 6'o05, 5, 5, 5);
    chk("lui no stall", m_pc_we, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) drive(1, 1, 0, 0, 6'o77, 0, 0, 0);
    drive(0, 1, 0, 0, 6'o77, 0, 0, 0);
    chk("sat s_stall_cnt", s_stall, 15);
    chk("sat m_stall_cnt", m_stall, 20);
    chk("sat state", m_state, 3);
    idle();
    chk("post-rst state", m_state, 0);
    chk("post-rst s_stall_cnt", s_stall, 0);
    chk("post-rst s_redir_cnt", s_redir, 0);
    chk("post-rst pc_we", m_pc_we, 1);
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 99) >= 3, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15,
            $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0 ? 6'($urandom) : ops[$urandom_range(0, 11)],
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
